// File: rtl/tone_synth.sv
// tone_synth: handshake-driven square-wave note generator.
// A note (key, duration) is accepted over REQ/ACK and played for DUR prescaled
// ticks; the speaker is driven differentially from the accumulator MSB.
// Optional feature macro: TONE_SYNTH_GAP_EN adds a silent GAP state of
// C_GAP_TICKS ticks after every note.
//
// Handshake: REQ_i is a level held by the sequencer until it sees ACK_o. A
// note is taken at any edge where the block is IDLE and REQ_i is high; ACK_o
// is a registered one-cycle pulse in the following cycle. REQ_i is ignored
// while BUSY_o is high, so a request held across a note's end is taken at the
// edge that closes the DONE_o cycle.
module tone_synth #(
  parameter int C_PRESCALE  = 256,
  parameter int C_ACC_W     = 16,
  parameter int C_KEY_W     = 8,
  parameter int C_DUR_W     = 12,
  parameter int C_BASE      = 85,
  parameter int C_GAP_TICKS = 1
) (
  input  logic               CK_i,
  input  logic               ARST_i,
  input  logic               REQ_i,
  input  logic [C_KEY_W-1:0] KEY_i,
  input  logic [C_DUR_W-1:0] DUR_i,
  input  logic               STOP_i,
  output logic               ACK_o,
  output logic               BUSY_o,
  output logic               DONE_o,
  output logic               SOUND_o,
  output logic               XSOUND_o,
  output logic [C_ACC_W-1:0] SOUND_CTR_o,
  output logic [1:0]         DBG_STATE_o
);

  localparam int PRE_W = (C_PRESCALE > 2) ? $clog2(C_PRESCALE) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(C_PRESCALE - 1);
  localparam logic [C_ACC_W-1:0] BASE_W   = C_ACC_W'(C_BASE);

  // Reject configurations the arithmetic below cannot honour.
  if (C_PRESCALE < 2 || C_GAP_TICKS < 1 || C_ACC_W < C_KEY_W + 2) begin : g_bad_cfg
    $error("tone_synth: illegal parameter combination");
  end

`ifdef TONE_SYNTH_GAP_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1} state_t;
`endif

  state_t               state_q, state_d;
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic [C_DUR_W-1:0]   rem_q, rem_d;
  logic [C_ACC_W-1:0]   inc_q, inc_d;
  logic [C_ACC_W-1:0]   acc_q, acc_d;
  logic [C_KEY_W-1:0]   key_q, key_d;
  logic                 ack_q, ack_d;
  logic                 done_q, done_d;
  logic                 sound_q, sound_d;
  logic                 xsound_q, xsound_d;
  logic                 tick;
  logic                 leave_play;

  // Next-state and datapath: accept, tick counting, note end, abort.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    rem_d      = rem_q;
    inc_d      = inc_q;
    acc_d      = acc_q;
    key_d      = key_q;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    leave_play = 1'b0;
    tick       = (pre_q == PRE_LAST);

    case (state_q)
      ST_IDLE: begin
        if (REQ_i) begin
          key_d   = KEY_i;
          inc_d   = BASE_W + C_ACC_W'(KEY_i);
          acc_d   = '0;
          pre_d   = '0;
          rem_d   = DUR_i;
          ack_d   = 1'b1;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        if (STOP_i) begin
          // Abort wins over a coincident tick: the accumulator keeps its value.
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (rem_q == '0) begin
          // Zero-length note: leave without ever advancing the accumulator.
          leave_play = 1'b1;
        end else if (tick) begin
          acc_d = acc_q + inc_q;
          rem_d = rem_q - C_DUR_W'(1);
          if (rem_q == C_DUR_W'(1)) leave_play = 1'b1;
        end
      end
`ifdef TONE_SYNTH_GAP_EN
      ST_GAP: begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        if (STOP_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (tick) begin
          rem_d = rem_q - C_DUR_W'(1);
          if (rem_q <= C_DUR_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (leave_play) begin
`ifdef TONE_SYNTH_GAP_EN
      // The gap reuses the tick and remaining-count machinery from a clean start.
      state_d = ST_GAP;
      rem_d   = C_DUR_W'(C_GAP_TICKS);
      pre_d   = '0;
`else
      state_d = ST_IDLE;
      done_d  = 1'b1;
`endif
    end

    // Drive only while actually playing a non-rest key; otherwise no DC.
    sound_d  = 1'b0;
    xsound_d = 1'b0;
    if (state_q == ST_PLAY && key_q != '0) begin
      sound_d  = acc_q[C_ACC_W-1];
      xsound_d = ~acc_q[C_ACC_W-1];
    end
  end

  // State and output registers; reset aborts any note with no DONE pulse.
  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      state_q  <= ST_IDLE;
      pre_q    <= '0;
      rem_q    <= '0;
      inc_q    <= '0;
      acc_q    <= '0;
      key_q    <= '0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      sound_q  <= 1'b0;
      xsound_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      rem_q    <= rem_d;
      inc_q    <= inc_d;
      acc_q    <= acc_d;
      key_q    <= key_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      sound_q  <= sound_d;
      xsound_q <= xsound_d;
    end
  end

  assign ACK_o       = ack_q;
  assign BUSY_o      = (state_q != ST_IDLE);
  assign DONE_o      = done_q;
  assign SOUND_o     = sound_q;
  assign XSOUND_o    = xsound_q;
  assign SOUND_CTR_o = acc_q;
  assign DBG_STATE_o = state_q;

endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: directed checks of tone_synth with C_PRESCALE=4, C_ACC_W=16.
// Builds with or without TONE_SYNTH_GAP_EN (C_GAP_TICKS=2 adds 8 GAP cycles).
module tb_tone_synth;

  localparam int P = 4;
`ifdef TONE_SYNTH_GAP_EN
  localparam int GAP_CYC = 2 * P;
`else
  localparam int GAP_CYC = 0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        req  = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  key  = '0;
  logic [11:0] dur  = '0;
  logic        ack_o, busy_o, done_o, sound_o, xsound_o;
  logic [15:0] ctr_o;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  tone_synth #(
    .C_PRESCALE(P), .C_ACC_W(16), .C_KEY_W(8), .C_DUR_W(12),
    .C_BASE(85), .C_GAP_TICKS(2)
  ) dut (
    .CK_i(clk), .ARST_i(rst), .REQ_i(req), .KEY_i(key), .DUR_i(dur),
    .STOP_i(stop), .ACK_o(ack_o), .BUSY_o(busy_o), .DONE_o(done_o),
    .SOUND_o(sound_o), .XSOUND_o(xsound_o), .SOUND_CTR_o(ctr_o),
    .DBG_STATE_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Follow accumulator changes; with use_sb each new value must match exp_q.
  task automatic sb_track(input bit use_sb, input int idx,
                          inout logic [15:0] prev, inout int chg_idx);
    if (ctr_o != prev) begin
      if (chg_idx < 0) chg_idx = idx;
      if (use_sb) begin
        if (exp_q.size() == 0) check("acc_extra", ctr_o, prev);
        else                   check("acc_step", ctr_o, exp_q.pop_front());
      end
      prev = ctr_o;
    end
  endtask

  // Optionally request a note, then watch it until BUSY drops.
  // Returns in the first IDLE cycle. req_at/stop_at pulse REQ/STOP at that
  // busy-cycle index (0 = the ACK cycle); -1 disables.
  task automatic play(input bit do_accept, input bit hold, input logic [7:0] k,
                      input logic [11:0] d, input bit use_sb,
                      input int req_at, input int stop_at,
                      output int busy_n, output int ack_n, output int done_in,
                      output int snd_hi, output int bad, output int chg_idx);
    int          play_len;
    int          idx;
    logic [15:0] prev;
    play_len = (d == 0) ? 1 : int'(d) * P;
    if (do_accept) begin
      req = 1'b1; key = k; dur = d;
      step();
      if (!hold) req = 1'b0;
    end
    busy_n = 0; ack_n = 0; done_in = 0; snd_hi = 0; bad = 0; chg_idx = -1;
    prev = ctr_o;
    idx  = 0;
    while (busy_o && idx < 2000) begin
      ack_n   += int'(ack_o);
      done_in += int'(done_o);
      snd_hi  += int'(sound_o);
      if (k != 0 && idx >= 1 && idx <= play_len) begin
        if ((sound_o ^ xsound_o) !== 1'b1) bad++;
      end else if ((sound_o | xsound_o) !== 1'b0) begin
        bad++;
      end
      sb_track(use_sb, idx, prev, chg_idx);
      stop = (idx == stop_at);
      if (idx == req_at) begin
        req = 1'b1; key = 8'd9; dur = 12'd7;
      end else if (!hold) begin
        req = 1'b0;
      end
      busy_n++;
      idx++;
      step();
    end
    stop = 1'b0;
    check("note_ends", busy_o, 0);
    sb_track(use_sb, idx, prev, chg_idx);
  endtask

  // ---------------- directed sequence ----------------
  int busy_n, ack_n, done_in, snd_hi, bad, chg_idx;
  int dn, bs;

  initial begin
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    step();
    check("rst_ack", ack_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_sound", {sound_o, xsound_o}, 0);
    check("rst_ctr", ctr_o, 0);
    check("rst_state", dbg_state, 0);

    // Basic note: key 1 -> INC 86, three ticks.
    exp_q = {32'd86, 32'd172, 32'd258};
    play(1, 0, 8'd1, 12'd3, 1, -1, -1, busy_n, ack_n, done_in, snd_hi, bad, chg_idx);
    check("basic_ack", ack_n, 1);
    check("basic_busy", busy_n, 12 + GAP_CYC);
    check("basic_done_early", done_in, 0);
    check("basic_done", done_o, 1);
    check("basic_snd_hi", snd_hi, 0);
    check("basic_complement", bad, 0);
    check("basic_first_tick", chg_idx, P);
    check("basic_sb_left", exp_q.size(), 0);
    check("basic_ctr", ctr_o, 258);
    step();
    check("basic_done_once", done_o, 0);
    check("basic_silent_after", {sound_o, xsound_o}, 0);
    check("basic_ctr_hold", ctr_o, 258);

    // REQ pulsed mid-note is ignored.
    exp_q = {32'd86, 32'd172, 32'd258};
    play(1, 0, 8'd1, 12'd3, 1, 5, -1, busy_n, ack_n, done_in, snd_hi, bad, chg_idx);
    check("ignreq_ack", ack_n, 1);
    check("ignreq_busy", busy_n, 12 + GAP_CYC);
    check("ignreq_ctr", ctr_o, 258);
    check("ignreq_sb_left", exp_q.size(), 0);
    step();

    // Wrap: INC 340 x 200 ticks = 68000 mod 65536; MSB high for ticks 97..192.
    play(1, 0, 8'd255, 12'd200, 0, -1, -1, busy_n, ack_n, done_in, snd_hi, bad, chg_idx);
    check("wrap_busy", busy_n, 800 + GAP_CYC);
    check("wrap_ctr", ctr_o, 2464);
    check("wrap_snd_hi", snd_hi, 96 * P);
    check("wrap_complement", bad, 0);
    check("wrap_done", done_o, 1);
    step();

    // Rest: silent, but the accumulator still steps by 85 per tick.
    play(1, 0, 8'd0, 12'd5, 0, -1, -1, busy_n, ack_n, done_in, snd_hi, bad, chg_idx);
    check("rest_busy", busy_n, 20 + GAP_CYC);
    check("rest_silent", bad, 0);
    check("rest_ctr", ctr_o, 425);
    check("rest_done", done_o, 1);
    step();

    // Zero-length note.
    play(1, 0, 8'd5, 12'd0, 0, -1, -1, busy_n, ack_n, done_in, snd_hi, bad, chg_idx);
    check("zero_ack", ack_n, 1);
    check("zero_busy", busy_n, 1 + GAP_CYC);
    check("zero_ctr", ctr_o, 0);
    check("zero_no_tick", chg_idx, -1);
    check("zero_done", done_o, 1);
    step();
    check("zero_silent_after", {sound_o, xsound_o}, 0);

    // REQ held across the end: one IDLE cycle, then accepted again.
    exp_q = {32'd86, 32'd172, 32'd258};
    play(1, 1, 8'd1, 12'd3, 1, -1, -1, busy_n, ack_n, done_in, snd_hi, bad, chg_idx);
    check("held_done", done_o, 1);
    check("held_idle_gap", busy_o, 0);
    step();
    check("held_ack2", ack_o, 1);
    check("held_busy2", busy_o, 1);
    check("held_ctr_clear", ctr_o, 0);
    req = 1'b0;
    exp_q = {32'd86, 32'd172, 32'd258};
    play(0, 0, 8'd1, 12'd3, 1, -1, -1, busy_n, ack_n, done_in, snd_hi, bad, chg_idx);
    check("held2_busy", busy_n, 12 + GAP_CYC);
    check("held2_ctr", ctr_o, 258);
    check("held2_sb_left", exp_q.size(), 0);
    step();

    // STOP on the cycle of the second tick: abort wins, ACC stays at 86.
    exp_q = {32'd86};
    play(1, 0, 8'd1, 12'd3, 1, -1, 2 * P - 1, busy_n, ack_n, done_in, snd_hi, bad, chg_idx);
    check("stop_busy", busy_n, 2 * P);
    check("stop_ctr", ctr_o, 86);
    check("stop_done", done_o, 1);
    check("stop_sb_left", exp_q.size(), 0);
    step();
    check("stop_done_once", done_o, 0);

    // STOP while IDLE does nothing.
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("idle_stop_busy", busy_o, 0);
    check("idle_stop_done", done_o, 0);
    step();

`ifdef TONE_SYNTH_GAP_EN
    // STOP inside GAP (busy cycles 12..19).
    play(1, 0, 8'd1, 12'd3, 0, -1, 14, busy_n, ack_n, done_in, snd_hi, bad, chg_idx);
    check("gapstop_busy", busy_n, 15);
    check("gapstop_done", done_o, 1);
    check("gapstop_silent", bad, 0);
    step();
`endif

    // Reset mid-note: outputs clear at once, no DONE afterwards.
    req = 1'b1; key = 8'd255; dur = 12'd200;
    step();
    req = 1'b0;
    repeat (400) step();
    check("pre_rst_sound", sound_o, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_sound", {sound_o, xsound_o}, 0);
    check("arst_ctr", ctr_o, 0);
    check("arst_ack_done", {ack_o, done_o}, 0);
    step();
    #2 rst = 1'b0;
    dn = 0; bs = 0;
    repeat (3) begin
      step();
      dn += int'(done_o);
      bs += int'(busy_o);
    end
    check("post_rst_done", dn, 0);
    check("post_rst_busy", bs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
